// File: rtl/inst_prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encoding, queue entry
// layout and PC arithmetic helper.
package inst_prefetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          ENTRY_W          = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_prefetch_unit_fifo.sv
// DEPTH x W synchronous FIFO with push, pop, flush, occupancy count and head output.
// Flush has priority over push and pop.
module inst_prefetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [W-1:0]             i_data,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] STEP_C = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign w_do_pop  = i_pop & (r_count != '0);
  assign w_do_push = i_push & ((r_count != FULL_C) | w_do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + STEP_C;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + STEP_C;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch front end: fetches sequential words from a req/ack memory into a
// small {PC, Inst} queue feeding IF/ID, with branch redirect and wrong-path flush.
module inst_prefetch_unit
  import inst_prefetch_unit_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  input  logic        i_id_ready,
  output logic        o_i_valid,
  output logic [31:0] o_i_pc,
  output logic [31:0] o_i_pc4,
  output logic [31:0] o_i_inst
);
  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  fetch_state_e       r_state;
  logic [31:0]        r_fpc;
  logic [31:0]        r_mem_addr;
  logic               r_mem_req;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_count_after;
  logic [ENTRY_W-1:0] w_head_raw;
  fetch_entry_t       w_head;
  fetch_entry_t       w_push_entry;
  logic               w_valid;
  logic               w_push;
  logic               w_pop;
  logic [31:0]        w_fpc_inc;

  assign w_valid       = (w_count != '0);
  assign w_pop         = w_valid & i_id_ready;
  assign w_push        = (r_state == ST_WAIT) & i_mem_ack & ~i_redirect;
  // Occupancy once this cycle's ack is pushed (and any pop retired).
  assign w_count_after = w_count + ONE_C - (w_pop ? ONE_C : '0);
  assign w_fpc_inc     = pc_plus4(r_fpc);
  assign w_push_entry  = '{pc: r_mem_addr, inst: i_mem_data};
  assign w_head        = w_head_raw;

  inst_prefetch_unit_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_data  (w_push_entry),
    .o_head  (w_head_raw),
    .o_count (w_count)
  );

  // Fetch FSM; FPC always holds the address of the next word not yet pushed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_fpc      <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_redirect) begin
            r_fpc <= i_redirect_pc;
          end else if (w_count < DEPTH_C) begin
            r_state    <= ST_WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_fpc;
          end
        end
        ST_WAIT: begin
          if (i_redirect) begin
            r_fpc <= i_redirect_pc;
            if (i_mem_ack) begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end else begin
              r_state <= ST_DROP;
            end
          end else if (i_mem_ack) begin
            r_fpc <= w_fpc_inc;
            if (w_count_after < DEPTH_C) begin
              r_mem_addr <= w_fpc_inc;
            end else begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (i_redirect) r_fpc <= i_redirect_pc;
          if (i_mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_i_valid  = w_valid;
  assign o_i_pc     = w_valid ? w_head.pc : 32'h0;
  assign o_i_pc4    = w_valid ? pc_plus4(w_head.pc) : 32'h0;
  assign o_i_inst   = w_valid ? w_head.inst : 32'h0;

endmodule
